// File: rtl/bus_xfer_seq.sv
// Register-to-register transfer sequencer for the shared 8-bit tri-state bus.
// Drives one source onto the bus, lets it settle, then strobes the destination load.
//
// state | meaning
// IDLE  | waiting for a transfer request
// DRIVE | source enabled onto the bus, settle counter running
// LATCH | source still driving, destination load enable high
// DONE  | one-cycle completion pulse; a new request is accepted here too
module bus_xfer_seq #(
    parameter int NREG   = 6,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      src,
    input  logic [2:0]      dst,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            overrun,
    output logic [NREG-1:0] rd,
    output logic [NREG-1:0] wr
);

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH, DONE} state_t;

    localparam logic [3:0] NREG_L      = 4'(NREG);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [2:0]      src_q, src_nxt;
    logic [2:0]      dst_q, dst_nxt;
    logic            req_ok;
    logic            busy_nxt, done_nxt, err_nxt, overrun_nxt;
    logic [NREG-1:0] rd_nxt, wr_nxt;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        src_nxt     = src_q;
        dst_nxt     = dst_q;
        err_nxt     = 1'b0;
        overrun_nxt = overrun;
        req_ok      = ({1'b0, src} < NREG_L) && ({1'b0, dst} < NREG_L);

        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    if (req_ok) begin
                        state_nxt = DRIVE;
                        src_nxt   = src;
                        dst_nxt   = dst;
                        cnt_nxt   = SETTLE_INIT;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            DRIVE: begin
                overrun_nxt = overrun | start;
                if (cnt == 4'd0) begin
                    state_nxt = LATCH;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            LATCH: begin
                overrun_nxt = overrun | start;
                state_nxt   = DONE;
            end
            default: state_nxt = IDLE;
        endcase

        // Strobes are decoded from the next state so they leave the flops glitch-free.
        busy_nxt = (state_nxt == DRIVE) || (state_nxt == LATCH);
        done_nxt = (state_nxt == DONE);
        for (int i = 0; i < NREG; i++) begin
            rd_nxt[i] = busy_nxt && (src_nxt == 3'(i));
            wr_nxt[i] = (state_nxt == LATCH) && (dst_nxt == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            src_q   <= 3'd0;
            dst_q   <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            overrun <= 1'b0;
            rd      <= '0;
            wr      <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            src_q   <= src_nxt;
            dst_q   <= dst_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            overrun <= overrun_nxt;
            rd      <= rd_nxt;
            wr      <= wr_nxt;
        end
    end

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Bench for bus_xfer_seq: two instances (SETTLE=1 and SETTLE=3), each with a bus
// register model; data results go through a scoreboard queue checked on done.
module tb_bus_xfer_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start3;
    logic [2:0] src, dst;
    logic       busy1, done1, err1, overrun1;
    logic       busy3, done3, err3, overrun3;
    logic [5:0] rd1, wr1, rd3, wr3;
    logic       init_regs;

    logic [7:0] regs1 [6];
    logic [7:0] regs3 [6];
    logic [7:0] shadow1 [6];
    logic [7:0] bus1, bus3;

    typedef struct {
        logic [2:0] dst;
        logic [7:0] val;
    } exp_t;
    exp_t q1 [$];

    int n_pass  = 0;
    int n_total = 0;
    int run1    = 0;
    int run3    = 0;

    always #5 clk = ~clk;

    bus_xfer_seq #(.NREG(6), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .src(src), .dst(dst),
        .busy(busy1), .done(done1), .err(err1), .overrun(overrun1), .rd(rd1), .wr(wr1)
    );

    bus_xfer_seq #(.NREG(6), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .src(src), .dst(dst),
        .busy(busy3), .done(done3), .err(err3), .overrun(overrun3), .rd(rd3), .wr(wr3)
    );

    function automatic logic [7:0] init_val(input int i);
        case (i)
            0:       return 8'hA5;
            1:       return 8'h3C;
            2:       return 8'h22;
            3:       return 8'h33;
            4:       return 8'h44;
            default: return 8'h55;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always_comb begin
        bus1 = 8'h00;
        bus3 = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (rd1[i]) bus1 = bus1 | regs1[i];
            if (rd3[i]) bus3 = bus3 | regs3[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (init_regs) begin
                regs1[i] <= init_val(i);
                regs3[i] <= init_val(i);
            end else begin
                if (wr1[i]) regs1[i] <= bus1;
                if (wr3[i]) regs3[i] <= bus3;
            end
        end
    end

    // Invariants plus the scoreboard pop on each completed transfer.
    always @(negedge clk) begin
        exp_t e;
        run1 = (rd1 != 6'd0) ? run1 + 1 : 0;
        run3 = (rd3 != 6'd0) ? run3 + 1 : 0;
        if (rd1 != 6'd0) chk("rd1_onehot", 32'($countones(rd1)), 32'd1);
        if (rd3 != 6'd0) chk("rd3_onehot", 32'($countones(rd3)), 32'd1);
        if (wr1 != 6'd0) chk("wr1_settled", 32'(run1 >= 2), 32'd1);
        if (wr3 != 6'd0) chk("wr3_settled", 32'(run3 >= 4), 32'd1);
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("sb_data", 32'(regs1[e.dst]), 32'(e.val));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp1(input string tag, input logic [5:0] r, input logic [5:0] w,
                        input logic b, input logic d);
        chk({tag, "_rd1"},   32'(rd1),   32'(r));
        chk({tag, "_wr1"},   32'(wr1),   32'(w));
        chk({tag, "_busy1"}, 32'(busy1), 32'(b));
        chk({tag, "_done1"}, 32'(done1), 32'(d));
    endtask

    task automatic push1(input logic [2:0] s, input logic [2:0] d);
        exp_t e;
        shadow1[d] = shadow1[s];
        e.dst = d;
        e.val = shadow1[d];
        q1.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) shadow1[i] = init_val(i);
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; src = 3'd0; dst = 3'd0; init_regs = 1'b1;
        step(); step();
        exp1("reset", 6'b0, 6'b0, 1'b0, 1'b0);
        chk("reset_err1", 32'(err1), 32'd0);
        chk("reset_ovr1", 32'(overrun1), 32'd0);
        chk("reset_rd3", 32'(rd3), 32'd0);
        chk("reset_busy3", 32'(busy3), 32'd0);
        rst_n = 1'b1; init_regs = 1'b0;
        step();

        // SETTLE=1: 2 -> 5
        start1 = 1'b1; src = 3'd2; dst = 3'd5; push1(3'd2, 3'd5);
        step(); start1 = 1'b0;
        exp1("t1c1", 6'b000100, 6'b000000, 1'b1, 1'b0);
        step(); exp1("t1c2", 6'b000100, 6'b100000, 1'b1, 1'b0);
        step(); exp1("t1c3", 6'b000000, 6'b000000, 1'b0, 1'b1);
        step(); exp1("t1c4", 6'b000000, 6'b000000, 1'b0, 1'b0);

        // SETTLE=3: 0 -> 1
        start3 = 1'b1; src = 3'd0; dst = 3'd1;
        for (int c = 1; c <= 5; c++) begin
            step(); start3 = 1'b0;
            chk($sformatf("t2c%0d_rd3", c), 32'(rd3), (c <= 4) ? 32'h01 : 32'h00);
            chk($sformatf("t2c%0d_wr3", c), 32'(wr3), (c == 4) ? 32'h02 : 32'h00);
            chk($sformatf("t2c%0d_busy3", c), 32'(busy3), 32'(c <= 4));
            chk($sformatf("t2c%0d_done3", c), 32'(done3), 32'(c == 5));
        end
        chk("t2_reg1", 32'(regs3[1]), 32'hA5);
        step();

        // back-to-back 1 -> 3 -> 4
        start1 = 1'b1; src = 3'd1; dst = 3'd3; push1(3'd1, 3'd3);
        step(); start1 = 1'b0;
        exp1("t3c1", 6'b000010, 6'b000000, 1'b1, 1'b0);
        step(); exp1("t3c2", 6'b000010, 6'b001000, 1'b1, 1'b0);
        step(); exp1("t3c3", 6'b000000, 6'b000000, 1'b0, 1'b1);
        start1 = 1'b1; src = 3'd3; dst = 3'd4; push1(3'd3, 3'd4);
        step(); start1 = 1'b0;
        exp1("t3c4", 6'b001000, 6'b000000, 1'b1, 1'b0);
        step(); exp1("t3c5", 6'b001000, 6'b010000, 1'b1, 1'b0);
        step(); exp1("t3c6", 6'b000000, 6'b000000, 1'b0, 1'b1);
        chk("t3_reg4", 32'(regs1[4]), 32'h3C);
        chk("t3_ovr1", 32'(overrun1), 32'd0);
        step();

        // invalid indices
        start1 = 1'b1; src = 3'd6; dst = 3'd0;
        step(); start1 = 1'b0;
        chk("t4a_err1", 32'(err1), 32'd1);
        exp1("t4a", 6'b0, 6'b0, 1'b0, 1'b0);
        step(); chk("t4a_err1_off", 32'(err1), 32'd0);
        start1 = 1'b1; src = 3'd2; dst = 3'd7;
        step(); start1 = 1'b0;
        chk("t4b_err1", 32'(err1), 32'd1);
        exp1("t4b", 6'b0, 6'b0, 1'b0, 1'b0);
        step(); chk("t4b_err1_off", 32'(err1), 32'd0);

        // start during DRIVE: 0 -> 2 keeps its indices, overrun sticks
        start1 = 1'b1; src = 3'd0; dst = 3'd2; push1(3'd0, 3'd2);
        step();
        chk("t5c1_ovr1", 32'(overrun1), 32'd0);
        src = 3'd4; dst = 3'd5;
        step(); start1 = 1'b0;
        chk("t5c2_ovr1", 32'(overrun1), 32'd1);
        exp1("t5c2", 6'b000001, 6'b000100, 1'b1, 1'b0);
        step(); exp1("t5c3", 6'b000000, 6'b000000, 1'b0, 1'b1);
        step(); step();
        chk("t5_ovr1_sticky", 32'(overrun1), 32'd1);
        exp1("t5c5", 6'b000000, 6'b000000, 1'b0, 1'b0);

        // reset while dut1 in LATCH and dut3 in DRIVE: 5 -> 3
        start1 = 1'b1; start3 = 1'b1; src = 3'd5; dst = 3'd3;
        step(); start1 = 1'b0; start3 = 1'b0;
        step(); exp1("t6c2", 6'b100000, 6'b001000, 1'b1, 1'b0);
        chk("t6c2_rd3", 32'(rd3), 32'h20);
        rst_n = 1'b0;
        step();
        shadow1[3] = shadow1[5];
        exp1("t6r1", 6'b0, 6'b0, 1'b0, 1'b0);
        chk("t6r1_ovr1", 32'(overrun1), 32'd0);
        chk("t6r1_rd3", 32'(rd3), 32'd0);
        chk("t6r1_wr3", 32'(wr3), 32'd0);
        step();
        chk("t6r2_done1", 32'(done1), 32'd0);
        chk("t6r2_done3", 32'(done3), 32'd0);
        rst_n = 1'b1;
        step(); step();
        chk("t6_reg3_dut3", 32'(regs3[3]), 32'h33);
        chk("t6_done3", 32'(done3), 32'd0);

        // src == dst == 2
        start1 = 1'b1; src = 3'd2; dst = 3'd2; push1(3'd2, 3'd2);
        step(); start1 = 1'b0;
        exp1("t7c1", 6'b000100, 6'b000000, 1'b1, 1'b0);
        step(); exp1("t7c2", 6'b000100, 6'b000100, 1'b1, 1'b0);
        step(); exp1("t7c3", 6'b000000, 6'b000000, 1'b0, 1'b1);
        chk("t7_reg2", 32'(regs1[2]), 32'hA5);
        step(); step();

        chk("sb_empty", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
